// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types, limits and config normalisation for the UART transmit path.
package uart_tx_ctrl_pkg;

    typedef logic [7:0] serial_to_parallel_t;

    typedef struct packed {
        logic [31:0] baudRate;
        logic [3:0]  numDataBits;
        logic [1:0]  numStopBits;
        logic        parityEnable;
        logic        parityType;
    } uart_config_t;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic [3:0] UART_MIN_DATA_BITS = 4'd5;
    localparam logic [3:0] UART_MAX_DATA_BITS = 4'd8;
    localparam logic [1:0] UART_MAX_STOP_BITS = 2'd2;

    // Data bits forced into 5..8, stop bits into 1..2.
    function automatic uart_config_t uart_clamp_cfg(input uart_config_t cfg);
        uart_config_t r;
        r = cfg;
        if (cfg.numDataBits < UART_MIN_DATA_BITS) begin
            r.numDataBits = UART_MIN_DATA_BITS;
        end else if (cfg.numDataBits > UART_MAX_DATA_BITS) begin
            r.numDataBits = UART_MAX_DATA_BITS;
        end
        if (cfg.numStopBits == 2'd0) begin
            r.numStopBits = 2'd1;
        end else if (cfg.numStopBits > UART_MAX_STOP_BITS) begin
            r.numStopBits = UART_MAX_STOP_BITS;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-period timer: down-counter reloaded on frame start or at each bit end.
module uart_baud_tick #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 start_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 bit_end_o
);

    logic [DIV_WIDTH-1:0] per_q, per_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // cnt_q holds the cycles remaining in the current bit, including this one.
    assign bit_end_o = en_i && (cnt_q == DIV_WIDTH'(1));

    always_comb begin
        per_d = per_q;
        cnt_d = cnt_q;
        if (start_i) begin
            per_d = div_i;
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = bit_end_o ? per_q : cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            per_q <= '0;
            cnt_q <= '0;
        end else begin
            per_q <= per_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: START, DATA (LSB first), optional PARITY, STOP.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  uart_config_t         cfg_i,
    input  logic [DIV_WIDTH-1:0] clks_per_bit_i,
    input  serial_to_parallel_t  tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output uart_state_t          state_o
);

    uart_state_t          state_q, state_d;
    logic                 tx_q, tx_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           last_idx_q, last_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 nstop2_q, nstop2_d;
    logic                 accept;
    logic                 bit_end;
    logic [DIV_WIDTH-1:0] div_n;
    uart_config_t         cfg_n;
    logic                 unused_cfg;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_type_q, par_type_d;
    logic                 par_q, par_d;
    assign unused_cfg = ^cfg_n.baudRate;
`else
    assign unused_cfg = ^{cfg_n.baudRate, cfg_n.parityEnable, cfg_n.parityType};
`endif

    assign cfg_n      = uart_clamp_cfg(cfg_i);
    assign div_n      = (clks_per_bit_i == '0) ? DIV_WIDTH'(1) : clks_per_bit_i;
    assign accept     = (state_q == ST_IDLE) && tx_valid_i;
    assign tx_ready_o = (state_q == ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign tx_o       = tx_q;
    assign state_o    = state_q;
    assign done_o     = (state_q == ST_STOP) && bit_end && (stop_cnt_q == nstop2_q);

    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud (
        .clk      (clk),
        .arst     (arst),
        .start_i  (accept),
        .en_i     (busy_o),
        .div_i    (div_n),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_idx_d = last_idx_q;
        stop_cnt_d = stop_cnt_q;
        nstop2_d   = nstop2_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_d      = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    state_d    = ST_START;
                    tx_d       = ~IDLE_LEVEL;
                    shift_d    = tx_data_i;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    last_idx_d = 3'(cfg_n.numDataBits - 4'd1);
                    nstop2_d   = (cfg_n.numStopBits == 2'd2);
`ifdef UART_TX_PARITY_EN
                    par_en_d   = cfg_n.parityEnable;
                    par_type_d = cfg_n.parityType;
                    par_d      = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_cnt_q == last_idx_q) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q ^ shift_q[0] ^ par_type_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = IDLE_LEVEL;
                        end
`else
                        state_d = ST_STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == nstop2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_IDLE;
            tx_q       <= IDLE_LEVEL;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            last_idx_q <= '0;
            stop_cnt_q <= 1'b0;
            nstop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_idx_q <= last_idx_d;
            stop_cnt_q <= stop_cnt_d;
            nstop2_q   <= nstop2_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side sequencer for the AXI-to-UART bridge. It accepts one parallel byte per valid/ready handshake and serialises it onto the UART TX line. The frame is START, DATA (LSB first), optional PARITY, then STOP, using the frame fields of uart_config_t and a programmable bit period. It sits between the AXI write-data path and the TX pin, and it owns the baud timing for transmission.

Parameters:
- DIV_WIDTH, 16, width of the clocks-per-bit divisor.
- IDLE_LEVEL, 1'b1, line level driven when idle and during stop bits.

Ports:
- clk  input  1  system clock.
- arst  input  1  asynchronous active-high reset.
- cfg_i  input  uart_config_t  frame config. baudRate field is unused here; timing comes from clks_per_bit_i.
- clks_per_bit_i  input  DIV_WIDTH  clk cycles per UART bit.
- tx_data_i  input  8 (serial_to_parallel_t)  byte to send.
- tx_valid_i  input  1  byte available.
- tx_ready_o  output  1  block can accept a byte.
- tx_o  output  1  serial line (registered).
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse at end of final stop bit.
- state_o  output  uart_state_t  current state, for debug and coverage.

Behaviour:
- Clock and reset: one clock, clk. Reset arst is asynchronous and active-high.
- Reset values: tx_o=IDLE_LEVEL, tx_ready_o=1, busy_o=0, done_o=0, state_o=IDLE, all counters 0.
- tx_ready_o = (state==IDLE), with no combinational path from tx_valid_i.
- Accept: tx_valid_i && tx_ready_o at a rising edge. At that edge the block latches tx_data_i, cfg_i and clks_per_bit_i. Changes to these inputs mid-frame are ignored.
- Latency: tx_o goes low (start bit) on the edge after accept.
- Bit period: N = latched clks_per_bit; N=0 is treated as 1. Every bit holds for exactly N cycles.
- Data bit count: numDataBits clamped to 5..8 (values <5 become 5, >8 become 8).
- Stop bit count: numStopBits 0 is treated as 1; 3 is treated as 2.
- State transitions:
  - IDLE -> START on accept.
  - START -> DATA after N cycles.
  - DATA -> PARITY after the last data bit if parityEnable=1, else DATA -> STOP.
  - PARITY -> STOP after N cycles.
  - STOP -> IDLE after the last stop bit.
- Parity bit: XOR of the transmitted data bits when parityType=0 (even); inverted XOR when parityType=1 (odd).
- Frame length: (1 + data bits + parity bit + stop bits)·N cycles.
- done_o pulses in the last cycle of the final stop bit.
- Back-to-back frames: IDLE lasts at least one cycle, so the line stays high for ≥N+1 cycles between frames when one stop bit is used.
- busy_o = (state != IDLE).
- Reset mid-frame: the block returns to IDLE immediately and tx_o goes high with no glitch low. The partially sent byte is dropped.
- tx_valid_i while busy is simply not accepted; the data is held by the upstream block.

Optional Feature:
- UART_TX_PARITY_EN defined: parity behaves as described above.
- UART_TX_PARITY_EN undefined: parityEnable and parityType are ignored, the PARITY state is never entered, and no parity logic is synthesised.

Decomposition:
- Shared package (tb_pkg) additions: UART_MIN_DATA_BITS=5, UART_MAX_DATA_BITS=8, UART_MAX_STOP_BITS=2.
- Shared package also gets the function uart_clamp_cfg(uart_config_t) returning the normalised config. The existing uart_state_t is reused for the states.
- Sub-module: uart_baud_tick. It holds a DIV_WIDTH down-counter that reloads on start or tick and produces a bit_end pulse every N cycles. The FSM and shift register stay in uart_tx_ctrl.

Test Plan:
- 8N1, N=4, byte 0xA5 -> tx_o bits 0,1,0,1,0,0,1,0,1,1, 4 cycles each; done_o pulses at cycle 40 after the start bit begins; tx_ready_o is low for 40 cycles.
- 8E1 then 8O1, N=2, byte 0xA5 -> parity bit 0 (even) and 1 (odd); frame is 22 cycles.
- 5 data bits with numDataBits=3, 2 stop bits, N=1, byte 0xFF -> 0,1,1,1,1,1,1,1: clamped to 5 data bits, 8-cycle frame.
- Two bytes 0x00,0xFF with tx_valid_i held high, N=3 -> second start bit begins 1 cycle after the first frame's IDLE. clks_per_bit_i changed to 7 mid-frame has no effect on the current frame.
- arst asserted at cycle 10 of a 0x55 frame -> tx_o=1, state_o=IDLE, tx_ready_o=1 asynchronously. After release, a new byte 0x3C transmits correctly.
- N=0 with byte 0x81, 8N1 -> each bit lasts 1 cycle, 10-cycle frame.
